// File: rtl/animator_pkg.sv
// Shared encodings and width rules for the animator pipeline.
// Optional feature macro used by this slice: ANIMATOR_SETTLED_EN.
package animator_pkg;

   localparam logic c_mode_linear = 1'b0;
   localparam logic c_mode_exp    = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Signed difference of two unsigned channel values needs one extra bit.
   function automatic int step_diff_w(input int bpc);
      return bpc + 1;
   endfunction

endpackage

// File: rtl/animator_step.sv
// One registered stage moving a current channel value toward its target.
// With ANIMATOR_SETTLED_EN it also reports whether the new value equals the target.
module animator_step
   import animator_pkg::*;
#(
   parameter int c_bpc     = 12,
   parameter int c_shift_w = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic                 i_mode,
   input  logic [c_bpc-1:0]     i_step,
   input  logic [c_shift_w-1:0] i_shift,
   input  logic [c_bpc-1:0]     i_target,
   input  logic [c_bpc-1:0]     i_current,
   output logic [c_bpc-1:0]     o_value
`ifdef ANIMATOR_SETTLED_EN
  ,output logic                 o_hit
`endif
);

   localparam int c_dw = step_diff_w(c_bpc);
   localparam logic signed [c_dw-1:0] c_pos_one = c_dw'(1);
   localparam logic signed [c_dw-1:0] c_neg_one = {c_dw{1'b1}};

   logic signed [c_dw-1:0] diff_s;
   logic signed [c_dw-1:0] mag_s;
   logic signed [c_dw-1:0] shifted_s;
   logic signed [c_dw-1:0] delta_s;
   logic signed [c_dw-1:0] sum_s;
   logic [c_bpc-1:0]       new_s;
   int                     sh_s;

   // Next channel value; the exponential step is forced to at least one LSB so it always converges.
   always_comb begin
      new_s     = i_current;
      diff_s    = $signed({1'b0, i_target}) - $signed({1'b0, i_current});
      mag_s     = diff_s[c_dw-1] ? -diff_s : diff_s;
      sh_s      = (int'(i_shift) > c_bpc) ? c_bpc : int'(i_shift);
      shifted_s = diff_s >>> sh_s;
      delta_s   = ((shifted_s == '0) && (diff_s != '0)) ?
                  (diff_s[c_dw-1] ? c_neg_one : c_pos_one) : shifted_s;
      sum_s     = $signed({1'b0, i_current}) + delta_s;
      case (i_mode)
         c_mode_linear: begin
            if (mag_s <= $signed({1'b0, i_step})) begin
               new_s = i_target;
            end else if (diff_s[c_dw-1]) begin
               new_s = i_current - i_step;
            end else begin
               new_s = i_current + i_step;
            end
         end
         c_mode_exp: new_s = sum_s[c_bpc-1:0];
         default:    new_s = i_current;
      endcase
   end

   // Output register, loaded only for valid pipeline slots.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_value <= '0;
`ifdef ANIMATOR_SETTLED_EN
         o_hit   <= 1'b0;
`endif
      end else if (i_en) begin
         o_value <= new_s;
`ifdef ANIMATOR_SETTLED_EN
         o_hit   <= (new_s == i_target);
`endif
      end
   end

endmodule

// File: rtl/animator_pipe.sv
// Per-frame channel animator: sweeps all channels at one per clock, with request queuing.
// Optional o_settled status is built when ANIMATOR_SETTLED_EN is defined.
module animator_pipe
   import animator_pkg::*;
#(
   parameter int c_ledboards = 30,
   parameter int c_channels  = c_ledboards * 32,
   parameter int c_addr_w    = $clog2(c_channels),
   parameter int c_bpc       = 12,
   parameter int c_shift_w   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_drq,
   input  logic                 i_mode,
   input  logic [c_bpc-1:0]     i_step,
   input  logic [c_shift_w-1:0] i_shift,
   input  logic [c_bpc-1:0]     i_target_data,
   input  logic [c_bpc-1:0]     i_current_data,
   output logic [c_addr_w-1:0]  o_target_raddr,
   output logic [c_addr_w-1:0]  o_current_raddr,
   output logic [c_addr_w-1:0]  o_current_waddr,
   output logic                 o_current_wen,
   output logic [c_bpc-1:0]     o_current_data,
   output logic                 o_busy,
   output logic                 o_done
`ifdef ANIMATOR_SETTLED_EN
  ,output logic                 o_settled
`endif
);

   localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(c_channels - 1);

   state_t                 state_r;
   logic [c_addr_w-1:0]    cnt_r;
   logic [c_addr_w-1:0]    addr1_r;
   logic                   pending_r;
   logic                   drain_r;
   logic                   valid1_r;
   logic                   mode_r;
   logic [c_bpc-1:0]       step_r;
   logic [c_shift_w-1:0]   shift_r;
   logic                   start_s;
   logic                   finish_s;

   assign start_s         = (state_r == ST_IDLE) && (i_drq || pending_r);
   assign finish_s        = (state_r == ST_DRAIN) && drain_r;
   assign o_target_raddr  = cnt_r;
   assign o_current_raddr = cnt_r;

   // Sweep FSM: address counter, request queuing, busy/done status and ramp parameter capture.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         pending_r <= 1'b0;
         drain_r   <= 1'b0;
         mode_r    <= c_mode_linear;
         step_r    <= '0;
         shift_r   <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r   <= ST_SWEEP;
                  cnt_r     <= '0;
                  pending_r <= 1'b0;
                  o_busy    <= 1'b1;
                  mode_r    <= i_mode;
                  step_r    <= i_step;
                  shift_r   <= i_shift;
               end
            end
            ST_SWEEP: begin
               pending_r <= pending_r | i_drq;
               if (cnt_r == c_last_addr) begin
                  cnt_r   <= '0;
                  drain_r <= 1'b0;
                  state_r <= ST_DRAIN;
               end else begin
                  cnt_r <= cnt_r + c_addr_w'(1);
               end
            end
            ST_DRAIN: begin
               pending_r <= pending_r | i_drq;
               if (drain_r) begin
                  drain_r <= 1'b0;
                  state_r <= ST_IDLE;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
               end else begin
                  drain_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
               drain_r <= 1'b0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Valid/address shift register aligning the write with the RAM read latency plus the step stage.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid1_r        <= 1'b0;
         addr1_r         <= '0;
         o_current_wen   <= 1'b0;
         o_current_waddr <= '0;
      end else begin
         valid1_r        <= (state_r == ST_SWEEP);
         addr1_r         <= cnt_r;
         o_current_wen   <= valid1_r;
         o_current_waddr <= addr1_r;
      end
   end

`ifdef ANIMATOR_SETTLED_EN
   logic hit_s;
   logic all_hit_r;
   logic all_hit_s;

   assign all_hit_s = all_hit_r & (~o_current_wen | hit_s);

   // Settled tracking: AND of per-channel hits over one sweep, published with o_done.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         all_hit_r <= 1'b0;
         o_settled <= 1'b0;
      end else begin
         all_hit_r <= start_s ? 1'b1 : all_hit_s;
         if (finish_s) begin
            o_settled <= all_hit_s;
         end
      end
   end
`endif

   animator_step #(
      .c_bpc     (c_bpc),
      .c_shift_w (c_shift_w)
   ) u_step (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (valid1_r),
      .i_mode    (mode_r),
      .i_step    (step_r),
      .i_shift   (shift_r),
      .i_target  (i_target_data),
      .i_current (i_current_data),
      .o_value   (o_current_data)
`ifdef ANIMATOR_SETTLED_EN
     ,.o_hit     (hit_s)
`endif
   );

endmodule

// File: tb/tb_animator_pipe.sv
// Directed bench for animator_pipe with 4 channels and a behavioural target/current RAM pair.
module tb_animator_pipe;

   logic        clk = 1'b0;
   logic        rst_n, drq, mode;
   logic [11:0] step;
   logic [3:0]  shift;
   logic [11:0] tdata, cdata, wdata;
   logic [1:0]  traddr, craddr, waddr;
   logic        wen, busy, done;
`ifdef ANIMATOR_SETTLED_EN
   logic        settled;
`endif
   logic [11:0] tgt [4];
   logic [11:0] cur [4];
   logic        bw_en;
   logic [1:0]  bw_addr;
   logic [11:0] bw_data;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   animator_pipe #(.c_ledboards(1), .c_channels(4), .c_addr_w(2), .c_bpc(12), .c_shift_w(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_drq(drq), .i_mode(mode), .i_step(step), .i_shift(shift),
      .i_target_data(tdata), .i_current_data(cdata),
      .o_target_raddr(traddr), .o_current_raddr(craddr), .o_current_waddr(waddr),
      .o_current_wen(wen), .o_current_data(wdata), .o_busy(busy), .o_done(done)
`ifdef ANIMATOR_SETTLED_EN
     ,.o_settled(settled)
`endif
   );

   // RAMs with 1-cycle read latency; bench preload port used only while the DUT is idle.
   always @(posedge clk) begin
      tdata <= tgt[traddr];
      cdata <= cur[craddr];
      if (wen) cur[waddr] <= wdata;
      else if (bw_en) cur[bw_addr] <= bw_data;
   end

   task automatic load(input int i, input logic [11:0] t, input logic [11:0] c);
      tgt[i] = t;
      @(negedge clk); bw_en = 1'b1; bw_addr = 2'(i); bw_data = c;
      @(negedge clk); bw_en = 1'b0;
   endtask

   task automatic run_sweep(output int nw);
      int cyc = 0;
      nw = 0;
      @(negedge clk); drq = 1'b1;
      @(negedge clk); drq = 1'b0;
      while (!done && cyc < 50) begin
         if (wen) nw++;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL sweep_timeout: done=%b after %0d cycles, required 1", done, cyc);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, wen} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: busy/done/wen=%b required 000", {busy, done, wen});
      end
      checks++;
      if ({traddr, craddr, waddr} !== 6'd0) begin
         errors++; $display("FAIL reset_addr: addrs=%h required 0", {traddr, craddr, waddr});
      end
      checks++;
      if (wdata !== 12'd0) begin
         errors++; $display("FAIL reset_data: got %0d required 0", wdata);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, wen, traddr} !== 4'd0) begin
         errors++; $display("FAIL idle_after_reset: busy/wen/raddr=%b required 0", {busy, wen, traddr});
      end
   endtask

   task automatic test_timing();
      int ea;
      load(0, 12'd11, 12'd0); load(1, 12'd22, 12'd0); load(2, 12'd33, 12'd0); load(3, 12'd44, 12'd0);
      mode = 1'b0; step = 12'd4095; shift = 4'd0;
      @(negedge clk); drq = 1'b1;
      @(negedge clk); drq = 1'b0;
      mode = 1'b1; step = 12'd1; shift = 4'd15;  // must be ignored: parameters are captured at start
      for (int c = 0; c < 8; c++) begin
         ea = (c < 4) ? c : 0;
         checks++;
         if (traddr !== 2'(ea) || craddr !== 2'(ea)) begin
            errors++; $display("FAIL raddr_c%0d: got %0d/%0d required %0d", c, traddr, craddr, ea);
         end
         checks++;
         if (wen !== (c >= 2 && c <= 5)) begin
            errors++; $display("FAIL wen_c%0d: got %b", c, wen);
         end
         checks++;
         if (busy !== (c <= 5) || done !== (c == 6)) begin
            errors++; $display("FAIL busy_done_c%0d: got busy=%b done=%b", c, busy, done);
         end
         if (c >= 2 && c <= 5) begin
            checks++;
            if (waddr !== 2'(c - 2) || wdata !== tgt[c-2]) begin
               errors++; $display("FAIL wr_c%0d: got addr %0d data %0d required %0d data %0d",
                                  c, waddr, wdata, c - 2, tgt[c-2]);
            end
         end
         @(negedge clk);
      end
      mode = 1'b0; step = 12'd0; shift = 4'd0;
   endtask

   task automatic test_linear();
      logic [11:0] e [4][4];
      int nw;
      e = '{'{12'd116, 12'd124, 12'd50, 12'd16}, '{12'd132, 12'd108, 12'd50, 12'd32},
            '{12'd140, 12'd100, 12'd50, 12'd48}, '{12'd140, 12'd100, 12'd50, 12'd64}};
      load(0, 12'd140, 12'd100); load(1, 12'd100, 12'd140); load(2, 12'd50, 12'd50); load(3, 12'd4095, 12'd0);
      mode = 1'b0; step = 12'd16;
      for (int s = 0; s < 4; s++) begin
         run_sweep(nw);
         checks++;
         if (nw !== 4) begin
            errors++; $display("FAIL lin_writes_s%0d: got %0d required 4", s, nw);
         end
         for (int ch = 0; ch < 4; ch++) begin
            checks++;
            if (cur[ch] !== e[s][ch]) begin
               errors++; $display("FAIL lin_s%0d_ch%0d: got %0d required %0d", s, ch, cur[ch], e[s][ch]);
            end
         end
      end
   endtask

   task automatic test_step_zero();
      int nw;
      load(0, 12'd10, 12'd4000); load(1, 12'd4095, 12'd0); load(2, 12'd10, 12'd4000); load(3, 12'd0, 12'd4000);
      mode = 1'b0; step = 12'd0;
      run_sweep(nw);
      checks++;
      if (nw !== 4 || cur[0] !== 12'd4000 || cur[1] !== 12'd0 || cur[2] !== 12'd4000 || cur[3] !== 12'd4000) begin
         errors++; $display("FAIL step_zero: got w=%0d %0d %0d %0d %0d required 4 4000 0 4000 4000",
                            nw, cur[0], cur[1], cur[2], cur[3]);
      end
   endtask

   task automatic test_exp();
      logic [11:0] e0 [4];
      logic [11:0] e1 [4];
      int nw;
      e0 = '{12'd25, 12'd43, 12'd57, 12'd67};
      e1 = '{12'd75, 12'd56, 12'd42, 12'd31};
      load(0, 12'd100, 12'd0); load(1, 12'd0, 12'd100); load(2, 12'd4095, 12'd4095); load(3, 12'd11, 12'd10);
      mode = 1'b1; shift = 4'd2;
      for (int s = 0; s < 18; s++) begin
         run_sweep(nw);
         if (s < 4) begin
            checks++;
            if (cur[0] !== e0[s] || cur[1] !== e1[s] || cur[2] !== 12'd4095 || cur[3] !== 12'd11) begin
               errors++; $display("FAIL exp_s%0d: got %0d %0d %0d %0d required %0d %0d 4095 11",
                                  s, cur[0], cur[1], cur[2], cur[3], e0[s], e1[s]);
            end
         end
         if (s == 15) begin
            checks++;
            if (cur[0] !== 12'd99) begin
               errors++; $display("FAIL exp_99: got %0d required 99", cur[0]);
            end
         end
         if (s >= 16) begin
            checks++;
            if (cur[0] !== 12'd100 || cur[1] !== 12'd0) begin
               errors++; $display("FAIL exp_final_s%0d: got %0d %0d required 100 0", s, cur[0], cur[1]);
            end
         end
      end
   endtask

   task automatic test_exp_bounds();
      int nw;
      load(0, 12'd4095, 12'd0); load(1, 12'd0, 12'd4095); load(2, 12'd200, 12'd7); load(3, 12'd5, 12'd5);
      mode = 1'b1; shift = 4'd15;
      run_sweep(nw);
      checks++;
      if (cur[0] !== 12'd1 || cur[1] !== 12'd4094 || cur[2] !== 12'd8 || cur[3] !== 12'd5) begin
         errors++; $display("FAIL exp_shift15: got %0d %0d %0d %0d required 1 4094 8 5", cur[0], cur[1], cur[2], cur[3]);
      end
      shift = 4'd0;
      run_sweep(nw);
      checks++;
      if (cur[0] !== 12'd4095 || cur[1] !== 12'd0 || cur[2] !== 12'd200 || cur[3] !== 12'd5) begin
         errors++; $display("FAIL exp_shift0: got %0d %0d %0d %0d required 4095 0 200 5", cur[0], cur[1], cur[2], cur[3]);
      end
      mode = 1'b0;
   endtask

   task automatic test_pending();
      int dcount = 0, d1 = -1, d2 = -1, nw = 0;
      logic busy7 = 1'b0;
      logic [1:0] ra8 = 2'd0;
      mode = 1'b0; step = 12'd1;
      @(negedge clk); drq = 1'b1;
      @(negedge clk); drq = 1'b0;
      for (int c = 0; c < 24; c++) begin
         if (done) begin
            dcount++;
            if (d1 < 0) d1 = c;
            else d2 = c;
         end
         if (wen) nw++;
         if (c == 7) busy7 = busy;
         if (c == 8) ra8 = traddr;
         drq = (c == 1 || c == 3 || c == 5);
         @(negedge clk);
      end
      drq = 1'b0;
      checks++;
      if (dcount !== 2 || d1 !== 6 || d2 !== 13) begin
         errors++; $display("FAIL pend_done: got count %0d at %0d,%0d required 2 at 6,13", dcount, d1, d2);
      end
      checks++;
      if (busy7 !== 1'b1 || ra8 !== 2'd1) begin
         errors++; $display("FAIL pend_restart: got busy7=%b raddr8=%0d required 1 1", busy7, ra8);
      end
      checks++;
      if (nw !== 8) begin
         errors++; $display("FAIL pend_writes: got %0d required 8", nw);
      end
   endtask

   task automatic test_reset_mid();
      int nw = 0, nd = 0;
      @(negedge clk); drq = 1'b1;
      @(negedge clk); drq = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (wen !== 1'b1) begin
         errors++; $display("FAIL mid_pre_wen: got %b required 1", wen);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wen, busy, done, traddr} !== 5'd0) begin
         errors++; $display("FAIL mid_reset: wen/busy/done/raddr=%b required 0", {wen, busy, done, traddr});
      end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (wen) nw++;
         if (done) nd++;
         @(negedge clk);
      end
      checks++;
      if (nw !== 0 || nd !== 0) begin
         errors++; $display("FAIL mid_quiet: got writes %0d dones %0d required 0 0", nw, nd);
      end
      run_sweep(nw);
      checks++;
      if (nw !== 4) begin
         errors++; $display("FAIL mid_restart: got %0d writes required 4", nw);
      end
   endtask

`ifdef ANIMATOR_SETTLED_EN
   task automatic test_settled();
      logic ex [4];
      int nw;
      ex = '{1'b0, 1'b0, 1'b1, 1'b1};
      load(0, 12'd140, 12'd100); load(1, 12'd7, 12'd7); load(2, 12'd7, 12'd7); load(3, 12'd7, 12'd7);
      mode = 1'b0; step = 12'd16;
      for (int s = 0; s < 4; s++) begin
         run_sweep(nw);
         checks++;
         if (settled !== ex[s]) begin
            errors++; $display("FAIL settled_s%0d: got %b required %b", s, settled, ex[s]);
         end
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0; drq = 1'b0; mode = 1'b0; step = 12'd0; shift = 4'd0;
      bw_en = 1'b0; bw_addr = 2'd0; bw_data = 12'd0;
      repeat (3) @(negedge clk);
      test_reset();
      test_timing();
      test_linear();
      test_step_zero();
      test_exp();
      test_exp_bounds();
      test_pending();
      test_reset_mid();
`ifdef ANIMATOR_SETTLED_EN
      test_settled();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
